ser_cmd_ctl: RTL and testbench

Packet sequencer behind the serial byte receiver. It consumes the receiver's one-cycle byte strobe and data byte, and frames the bytes into checksummed command packets. It buffers the payload and presents each complete command to the GPU command logic over a valid/ready handshake. It also keeps saturating error counters for checksum, length and inter-byte-timeout failures, plus a sticky overrun flag.

---
 rtl/ser_pkg.sv | 23 ++
 rtl/ser_cmd_buf.sv | 29 ++
 rtl/ser_cmd_ctl.sv | 156 +++++++++++++++
 tb/tb_ser_cmd_ctl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared serial-link definitions: framing constants, sizes and the command FSM states.
// Used by the receiver, the command sequencer and the future transmitter.
package ser_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned MAX_LEN       = 16;
  localparam int unsigned LEN_W         = 5;
  localparam int unsigned IDX_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPC  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } cmd_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ser_cmd_buf.sv
// Payload buffer: MAX_LEN x 8 registers, one synchronous write port, one combinational read port.
module ser_cmd_buf
  import ser_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem_q [MAX_LEN];
  logic [7:0] mem_d [MAX_LEN];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/ser_cmd_ctl.sv
// Frames received bytes into checksummed command packets and hands them to the GPU command
// logic over valid/ready; keeps saturating error counters and a sticky overrun flag.
module ser_cmd_ctl
  import ser_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_full,
  input  logic [7:0]       rx_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_opcode,
  output logic [LEN_W-1:0] cmd_len,
  input  logic [IDX_W-1:0] cmd_rd_addr,
  output logic [7:0]       cmd_rd_data,
  input  logic             err_clr,
  output logic [7:0]       err_chk_count,
  output logic [7:0]       err_len_count,
  output logic [7:0]       err_timeout_count,
  output logic             overrun
);

  cmd_state_e       state_q, state_d;
  logic [7:0]       opc_q, opc_d;
  logic [7:0]       chk_q, chk_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [15:0]      to_q, to_d;
  logic [7:0]       err_chk_q, err_chk_d;
  logic [7:0]       err_len_q, err_len_d;
  logic [7:0]       err_to_q, err_to_d;
  logic             ovr_q, ovr_d;
  logic             buf_we, len_bad, chk_bad, to_hit;

  ser_cmd_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q[IDX_W-1:0]),
    .wdata (rx_data),
    .raddr (cmd_rd_addr),
    .rdata (cmd_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      chk_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      to_q      <= '0;
      err_chk_q <= '0;
      err_len_q <= '0;
      err_to_q  <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      chk_q     <= chk_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      to_q      <= to_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    chk_d   = chk_q;
    len_d   = len_q;
    idx_d   = idx_q;
    to_d    = to_q;
    buf_we  = 1'b0;
    len_bad = 1'b0;
    chk_bad = 1'b0;
    to_hit  = 1'b0;
    case (state_q)
      ST_IDLE: if (rx_full && rx_data == SYNC_BYTE) state_d = ST_OPC;
      ST_OPC: if (rx_full) begin
        opc_d   = rx_data;
        chk_d   = rx_data;
        state_d = ST_LEN;
      end
      ST_LEN: if (rx_full) begin
        if (rx_data > 8'(MAX_LEN)) begin
          len_bad = 1'b1;
          state_d = ST_IDLE;
        end else begin
          len_d   = rx_data[LEN_W-1:0];
          chk_d   = chk_q ^ rx_data;
          idx_d   = '0;
          state_d = (rx_data == 8'd0) ? ST_CHK : ST_PAY;
        end
      end
      ST_PAY: if (rx_full) begin
        buf_we = 1'b1;
        chk_d  = chk_q ^ rx_data;
        idx_d  = idx_q + 5'd1;
        if (idx_q + 5'd1 == len_q) state_d = ST_CHK;
      end
      ST_CHK: if (rx_full) begin
        if (rx_data == chk_q) begin
          state_d = ST_HOLD;
        end else begin
          chk_bad = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: if (cmd_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Byte in the expiry cycle takes priority; the timeout abort overrides the case above.
    if (state_q inside {ST_OPC, ST_LEN, ST_PAY, ST_CHK}) begin
      if (rx_full) begin
        to_d = '0;
      end else if (to_q == 16'(TIMEOUT_CLKS - 1)) begin
        to_hit  = 1'b1;
        to_d    = '0;
        state_d = ST_IDLE;
      end else begin
        to_d = to_q + 16'd1;
      end
    end
  end

  always_comb begin
    err_chk_d = chk_bad ? sat_inc(err_chk_q) : err_chk_q;
    err_len_d = len_bad ? sat_inc(err_len_q) : err_len_q;
    err_to_d  = to_hit  ? sat_inc(err_to_q)  : err_to_q;
    ovr_d     = ovr_q | (state_q == ST_HOLD && rx_full);
    if (err_clr) begin
      err_chk_d = '0;
      err_len_d = '0;
      err_to_d  = '0;
      ovr_d     = 1'b0;
    end
  end

  always_comb begin
    cmd_valid         = (state_q == ST_HOLD);
    cmd_opcode        = opc_q;
    cmd_len           = len_q;
    err_chk_count     = err_chk_q;
    err_len_count     = err_len_q;
    err_timeout_count = err_to_q;
    overrun           = ovr_q;
  end

endmodule

// File: tb/tb_ser_cmd_ctl.sv
// Scoreboard bench for ser_cmd_ctl: stimulus queues expected commands, a consumer/monitor
// process pops and checks each presented command, plus directed checks of the error paths.
module tb_ser_cmd_ctl;

  localparam int TO = 20000;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_full;
  logic [7:0] rx_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_opcode;
  logic [4:0] cmd_len;
  logic [3:0] cmd_rd_addr;
  logic [7:0] cmd_rd_data;
  logic       err_clr;
  logic [7:0] err_chk_count;
  logic [7:0] err_len_count;
  logic [7:0] err_timeout_count;
  logic       overrun;

  typedef struct {
    logic [7:0] opc;
    int         len;
    logic [7:0] pay [2];
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   ack_en   = 1'b0;

  ser_cmd_ctl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_full           (rx_full),
    .rx_data           (rx_data),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_opcode        (cmd_opcode),
    .cmd_len           (cmd_len),
    .cmd_rd_addr       (cmd_rd_addr),
    .cmd_rd_data       (cmd_rd_data),
    .err_clr           (err_clr),
    .err_chk_count     (err_chk_count),
    .err_len_count     (err_len_count),
    .err_timeout_count (err_timeout_count),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_full = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_full = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] opc, input int len, input logic [7:0] p0,
                          input logic [7:0] p1);
    exp_t e;
    e.opc    = opc;
    e.len    = len;
    e.pay[0] = p0;
    e.pay[1] = p1;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || cmd_valid) && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1 check("cmd_drained", exp_q.size(), 0);
  endtask

  // Consumer/monitor: reads back each presented command and accepts it once ack_en allows.
  initial begin : monitor
    exp_t e;
    int   k;
    cmd_ready   = 1'b0;
    cmd_rd_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset && cmd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_opcode", cmd_opcode, e.opc);
          check("cmd_len", cmd_len, e.len);
          for (int i = 0; i < e.len; i++) begin
            cmd_rd_addr = 4'(i);
            #1 check("cmd_rd_data", cmd_rd_data, e.pay[i]);
            @(negedge clk);
          end
          k = 0;
          while (!ack_en && k < 1000) begin
            check("held_valid", cmd_valid, 1);
            check("held_opcode", cmd_opcode, e.opc);
            @(negedge clk);
            k++;
          end
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("valid_after_xfer", cmd_valid, 0);
      end
    end
  end

  initial begin : stim
    reset   = 1'b1;
    rx_full = 1'b0;
    rx_data = '0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", cmd_valid, 0);
    check("rst_opcode", cmd_opcode, 0);
    check("rst_len", cmd_len, 0);
    check("rst_chk", err_chk_count, 0);
    check("rst_ovr", overrun, 0);

    // Basic packet with junk lead-in, held with ready low.
    ack_en = 1'b0;
    push_exp(8'h01, 2, 8'h11, 8'h22);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    check("latency_pre", cmd_valid, 0);
    send_byte(8'h30);
    check("latency_post", cmd_valid, 1);
    repeat (6) @(posedge clk);
    #1 check("hold_opcode", cmd_opcode, 8'h01);
    check("hold_len", cmd_len, 2);
    ack_en = 1'b1;
    wait_idle();

    // Checksum failure, then zero-length good packet.
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h06);
    check("chk_err_cnt", err_chk_count, 1);
    check("chk_err_novalid", cmd_valid, 0);
    push_exp(8'h07, 0, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    wait_idle();

    // Oversize length; following 01 must be ignored in IDLE.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
    check("len_err_cnt", err_len_count, 1);
    send_byte(8'h01);
    push_exp(8'h02, 0, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    wait_idle();

    // Inter-byte timeout boundary.
    send_byte(8'hA5); send_byte(8'h01);
    repeat (TO - 1) @(posedge clk);
    #1 check("to_not_yet", err_timeout_count, 0);
    @(posedge clk);
    #1 check("to_expired", err_timeout_count, 1);

    // Byte exactly on the expiry cycle keeps the packet alive.
    push_exp(8'h01, 0, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h01);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h00);
    send_byte(8'h01);
    check("to_byte_wins", err_timeout_count, 1);
    wait_idle();

    // Overrun while a command is held.
    ack_en = 1'b0;
    push_exp(8'h09, 1, 8'h5A, 8'h00);
    send_byte(8'hA5); send_byte(8'h09); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h52);
    repeat (3) @(posedge clk);
    send_byte(8'hA5);
    check("overrun_set", overrun, 1);
    send_byte(8'h09); send_byte(8'h00); send_byte(8'h09);
    check("ovr_opcode", cmd_opcode, 8'h09);
    check("ovr_len", cmd_len, 1);
    check("ovr_valid", cmd_valid, 1);
    ack_en = 1'b1;
    wait_idle();
    repeat (5) @(posedge clk);
    #1 check("ovr_no_new_cmd", cmd_valid, 0);
    check("ovr_sticky", overrun, 1);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("clr_ovr", overrun, 0);
    check("clr_chk", err_chk_count, 0);
    check("clr_len", err_len_count, 0);
    check("clr_to", err_timeout_count, 0);

    // Reset mid-packet.
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    check("pre_rst_chk", err_chk_count, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h11);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_opcode", cmd_opcode, 0);
    check("mid_rst_len", cmd_len, 0);
    check("mid_rst_chk", err_chk_count, 0);
    push_exp(8'h03, 1, 8'h44, 8'h00);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h44); send_byte(8'h46);
    wait_idle();

    // Saturation of the checksum counter.
    for (int i = 0; i < 256; i++) begin
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      if (i == 254) check("sat_reach", err_chk_count, 255);
    end
    check("sat_hold", err_chk_count, 255);

    // Clear wins over a simultaneous increment.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    @(posedge clk);
    #1 rx_full = 1'b1;
    rx_data = 8'h01;
    err_clr = 1'b1;
    @(posedge clk);
    #1 rx_full = 1'b0;
    err_clr = 1'b0;
    check("clr_beats_inc", err_chk_count, 0);

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
